xbusdec: RTL and testbench
==========================

XBUSDEC -- requirements
Module: xbusdec

Interface
REQ-001 Parameter N_SLV, default 8: number of slave ports, range 1..16.
REQ-002 Parameter ADDR_W, default 12: controller data address width.
REQ-003 Parameter DATA_W, default 32: data bus width.
REQ-004 Parameter SLV_BASE, default all zeros, N_SLV*ADDR_W bits: base address of slave i at bits [i*ADDR_W +: ADDR_W].
REQ-005 Parameter SLV_MASK, default all zeros, N_SLV*ADDR_W bits: address bits compared for slave i.
REQ-006 Parameter CTRL_BASE, default all ones minus 1: STAT register; the SRST register is at CTRL_BASE+1.
REQ-007 Parameter TMO, default 15: wait-state timeout in cycles, range 1..255.
REQ-008 clk  in  1  single clock; all state changes on its rising edge.
REQ-009 rst  in  1  synchronous active-low reset.
REQ-010 m_sel, m_we  in  1 each  master access request and write enable.
REQ-011 m_addr  in  ADDR_W  master address.
REQ-012 m_wdata  in  DATA_W  master write data.
REQ-013 m_rdata  out  DATA_W  read data, valid only with m_ready.
REQ-014 m_ready, m_err  out  1 each  one-cycle completion pulse and error flag qualifying it.
REQ-015 s_sel, s_rst  out  N_SLV each  per-slave select and soft-reset pulse.
REQ-016 s_we  out  1; s_addr  out  ADDR_W; s_wdata  out  DATA_W: broadcast to all slaves.
REQ-017 s_rdata  in  N_SLV*DATA_W; s_ready  in  N_SLV: per-slave read data and completion.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP.
- One transaction outstanding at a time.
REQ-019 IDLE, m_sel=1: latch m_addr, m_we and m_wdata, then decode.
- Decode priority: CTRL_BASE and CTRL_BASE+1 first.
- Then slave i matches when (m_addr & MASK_i) == (BASE_i & MASK_i); the lowest matching index wins.
REQ-020 IDLE, slave hit: go to ACCESS with the timeout counter at 0.
REQ-021 IDLE, control-register hit or no match: go directly to RESP.
REQ-022 ACCESS: s_sel[i] held at 1; s_we, s_addr and s_wdata driven from the latches.
- s_ready[i] sampled each cycle; s_ready from other slaves is ignored.
REQ-023 ACCESS, s_ready[i]=1: capture s_rdata slice i (zero if write), go to RESP with m_err=0.
REQ-024 ACCESS, counter reaches TMO without s_ready: go to RESP with m_err=1, m_rdata=0.
- Dropped s_sel ends the slave access.
REQ-025 No match: RESP with m_err=1, m_rdata=0.
REQ-026 RESP lasts exactly one cycle: m_ready=1, m_err and m_rdata valid, then return to IDLE.
REQ-027 Minimum latencies, with m_sel sampled at cycle 0:
- Zero-wait slave: m_ready at cycle 2.
- Control register or unmapped address: m_ready at cycle 1.
REQ-028 The master holds its inputs stable until m_ready and deasserts m_sel the following cycle.
- m_sel still high in IDLE starts a new transaction.
REQ-029 STAT read returns {zeros, sticky_err, err_cnt[7:0]}.
- Any STAT write clears sticky_err and err_cnt.
REQ-030 Each unmapped or timed-out transaction sets sticky_err and increments err_cnt.
- err_cnt saturates at 255; the increment occurs in the RESP cycle.
REQ-031 SRST write: s_rst[j] = m_wdata[j] for j < N_SLV, pulsed during the RESP cycle only.
- SRST reads return 0.
REQ-032 s_sel is one-hot or zero at all times; no slave is selected outside ACCESS.

Reset
REQ-033 rst=0 at a clock edge, in any state (including mid-ACCESS):
- FSM returns to IDLE.
- m_ready, m_err, m_rdata, s_sel, s_rst, s_we, s_addr, s_wdata, the timeout counter, sticky_err and err_cnt all become 0.
REQ-034 An interrupted transaction produces no m_ready.

Structure
REQ-035 Shared header xbusdefs.vh holds:
- STAT/SRST offsets.
- FSM state encodings.
- STAT field positions.
- ERR_CNT_W=8.
REQ-036 One combinational sub-module xaddrmatch (parameters N_SLV, ADDR_W, SLV_BASE, SLV_MASK) outputs a hit flag and the one-hot match after priority resolution.

Verification
REQ-037 Slave 0 base 0x100, mask 0xF00, s_ready tied 1, read 0x104 with s_rdata0=0xCAFE -> m_ready at cycle 2, m_rdata=0xCAFE, m_err=0.
REQ-038 Slave 3 asserts s_ready after 5 cycles, write 0xA5 -> s_sel[3] high 6 cycles, s_wdata=0xA5, m_ready one pulse, m_err=0.
REQ-039 Slave never ready, TMO=15 -> m_ready with m_err=1, m_rdata=0, STAT reads 0x101.
REQ-040 256 unmapped accesses -> err_cnt=255; STAT write -> STAT reads 0.
REQ-041 SRST write 0x05 -> s_rst=0b00000101 for exactly one cycle.
- Overlapping slaves 1 and 2 -> only s_sel[1] asserted.
REQ-042 rst=0 mid-ACCESS -> next cycle all outputs 0, no m_ready; a following access completes normally.

Source files
------------

// File: rtl/xbusdec_pkg.sv
// Shared definitions for the xbusdec address decoder: FSM encoding,
// control-register offsets and STAT field layout.
package xbusdec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int STAT_OFS        = 0;
    localparam int SRST_OFS        = 1;
    localparam int ERR_CNT_W       = 8;
    localparam int STAT_CNT_LSB    = 0;
    localparam int STAT_STICKY_BIT = 8;

endpackage

// File: rtl/xbusdec_xaddrmatch.sv
// Combinational slave address match with lowest-index priority.
module xaddrmatch
    import xbusdec_pkg::*;
#(
    parameter int                        N_SLV    = 8,
    parameter int                        ADDR_W   = 12,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = '0
)(
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [N_SLV-1:0]  o_onehot
);

    // Walk from the top down so the lowest matching index overrides the rest.
    always_comb begin
        o_onehot = '0;
        o_hit    = 1'b0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((i_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_hit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbusdec.sv
// Single-master to N-slave bus decoder with wait-state timeout, error
// statistics (STAT) and per-slave soft reset (SRST) control registers.
module xbusdec
    import xbusdec_pkg::*;
#(
    parameter int                        N_SLV     = 8,
    parameter int                        ADDR_W    = 12,
    parameter int                        DATA_W    = 32,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE  = '0,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK  = '0,
    parameter logic [ADDR_W-1:0]         CTRL_BASE = {{(ADDR_W-1){1'b1}}, 1'b0},
    parameter int                        TMO       = 15
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_sel,
    input  logic                    m_we,
    input  logic [ADDR_W-1:0]       m_addr,
    input  logic [DATA_W-1:0]       m_wdata,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    m_ready,
    output logic                    m_err,
    output logic [N_SLV-1:0]        s_sel,
    output logic [N_SLV-1:0]        s_rst,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [N_SLV*DATA_W-1:0] s_rdata,
    input  logic [N_SLV-1:0]        s_ready
);

    localparam logic [ADDR_W-1:0] STAT_ADDR = CTRL_BASE + ADDR_W'(STAT_OFS);
    localparam logic [ADDR_W-1:0] SRST_ADDR = CTRL_BASE + ADDR_W'(SRST_OFS);
    localparam logic [7:0]        TMO_LAST  = 8'(TMO - 1);

    state_t                 r_state;
    logic [7:0]             r_cnt;
    logic                   r_sticky;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic                   w_hit;
    logic [N_SLV-1:0]       w_onehot;
    logic                   w_is_stat;
    logic                   w_is_srst;
    logic                   w_rdy;
    logic [DATA_W-1:0]      w_rd;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] stat_word(input logic sticky,
                                                    input logic [ERR_CNT_W-1:0] cnt);
        logic [DATA_W-1:0] w;
        w = '0;
        w[STAT_CNT_LSB +: ERR_CNT_W] = cnt;
        w[STAT_STICKY_BIT]           = sticky;
        return w;
    endfunction

    xaddrmatch #(
        .N_SLV    (N_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_match (
        .i_addr   (m_addr),
        .o_hit    (w_hit),
        .o_onehot (w_onehot)
    );

    assign w_is_stat = (m_addr == STAT_ADDR);
    assign w_is_srst = (m_addr == SRST_ADDR);

    // s_sel is one-hot, so masking by it isolates the active slave.
    assign w_rdy = |(s_ready & s_sel);
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (s_sel[i]) w_rd = w_rd | s_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_sticky  <= 1'b0;
            r_err_cnt <= '0;
            m_ready   <= 1'b0;
            m_err     <= 1'b0;
            m_rdata   <= '0;
            s_sel     <= '0;
            s_rst     <= '0;
            s_we      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
        end else begin
            m_ready <= 1'b0;
            s_rst   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (m_sel) begin
                        s_we    <= m_we;
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        if (w_is_stat) begin
                            r_state <= ST_RESP;
                            m_ready <= 1'b1;
                            m_err   <= 1'b0;
                            if (m_we) begin
                                r_sticky  <= 1'b0;
                                r_err_cnt <= '0;
                                m_rdata   <= '0;
                            end else begin
                                m_rdata <= stat_word(r_sticky, r_err_cnt);
                            end
                        end else if (w_is_srst) begin
                            r_state <= ST_RESP;
                            m_ready <= 1'b1;
                            m_err   <= 1'b0;
                            m_rdata <= '0;
                            if (m_we) s_rst <= m_wdata[N_SLV-1:0];
                        end else if (w_hit) begin
                            r_state <= ST_ACCESS;
                            s_sel   <= w_onehot;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_RESP;
                            m_ready <= 1'b1;
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_rdy) begin
                        r_state <= ST_RESP;
                        s_sel   <= '0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b0;
                        m_rdata <= s_we ? '0 : w_rd;
                    end else if (r_cnt == TMO_LAST) begin
                        r_state <= ST_RESP;
                        s_sel   <= '0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b1;
                        m_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    // Error accounting lands as the response retires.
                    if (m_err) begin
                        r_sticky  <= 1'b1;
                        r_err_cnt <= sat_inc(r_err_cnt);
                    end
                    r_state <= ST_IDLE;
                    m_err   <= 1'b0;
                    m_rdata <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xbusdec.sv
// Bench for xbusdec: vector table plus hand sequences for soft reset,
// error saturation and reset during a slave access.
module tb_xbusdec;

    localparam int N   = 8;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 15;

    localparam logic [N*AW-1:0] BASE = {12'h800, 12'h700, 12'h600, 12'h500,
                                        12'h400, 12'h200, 12'h200, 12'h100};
    localparam logic [N*AW-1:0] MASK = {12'hF80, 12'hF00, 12'hF00, 12'hFF0,
                                        12'hF00, 12'hE00, 12'hF00, 12'hF00};

    logic            clk = 1'b0;
    logic            rst;
    logic            m_sel, m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic            m_ready, m_err;
    logic [N-1:0]    s_sel, s_rst, s_ready;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [N*DW-1:0] s_rdata;

    xbusdec #(
        .N_SLV    (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .SLV_BASE (BASE),
        .SLV_MASK (MASK),
        .TMO      (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_sel   (m_sel),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .s_sel   (s_sel),
        .s_rst   (s_rst),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    initial forever #5 clk = ~clk;

    // Slave models: latency 0 means s_ready tied high, -1 means never ready.
    int lat_cfg [N] = '{0, 1, 0, 5, 2, -1, 0, 3};
    int selcnt  [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) selcnt[i] <= s_sel[i] ? selcnt[i] + 1 : 0;
    end

    always_comb begin
        s_ready = '0;
        s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            s_rdata[i*DW +: DW] = {8'(i), 24'h00CAFE};
            if (lat_cfg[i] == 0)
                s_ready[i] = 1'b1;
            else if (lat_cfg[i] > 0 && s_sel[i] && selcnt[i] >= lat_cfg[i])
                s_ready[i] = 1'b1;
        end
    end

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        logic [N-1:0]  sel;
        int            selcyc;
    } vec_t;

    exp_t         sbq[$];
    vec_t         tbl[$];
    int           n_vec = 0;
    int           n_mis = 0;
    int           r_lat, r_selcyc, r_rstcyc;
    logic [N-1:0] r_selacc, r_rstacc;
    logic [DW-1:0] r_swd;
    logic         r_swe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_rd, input logic exp_err, input string tag);
        exp_t e;
        bit   done;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sbq.push_back(e);
        r_lat = -1; r_selcyc = 0; r_rstcyc = 0;
        r_selacc = '0; r_rstacc = '0; r_swd = '0; r_swe = 1'b0;
        @(posedge clk); #1;
        m_sel = 1'b1; m_we = we; m_addr = addr; m_wdata = wd;
        done = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge clk);
            if (s_sel != '0) begin
                r_selcyc++;
                r_selacc |= s_sel;
                r_swd = s_wdata;
                r_swe = s_we;
            end
            if (s_rst != '0) begin
                r_rstcyc++;
                r_rstacc |= s_rst;
            end
            if (m_ready) begin
                r_lat = n - 1;
                done  = 1'b1;
                e = sbq.pop_front();
                check({tag, ".rdata"}, m_rdata, e.rdata);
                check({tag, ".err"}, 32'(m_err), 32'(e.err));
            end
        end
        if (!done) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s.ready: got no m_ready in 40 cycles, want one pulse", tag);
            e = sbq.pop_front();
        end
        @(posedge clk); #1;
        m_sel = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".m_ready"}, 32'(m_ready), 32'h0);
        check({tag, ".m_err"},   32'(m_err),   32'h0);
        check({tag, ".m_rdata"}, m_rdata,      32'h0);
        check({tag, ".s_sel"},   32'(s_sel),   32'h0);
        check({tag, ".s_rst"},   32'(s_rst),   32'h0);
        check({tag, ".s_we"},    32'(s_we),    32'h0);
        check({tag, ".s_addr"},  32'(s_addr),  32'h0);
        check({tag, ".s_wdata"}, s_wdata,      32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string tag;
        int    nrdy;

        rst = 1'b0; m_sel = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        //                we    addr     wdata         rdata         err   lat sel    selcyc
        tbl.push_back('{1'b0, 12'hFFE, 32'h0,        32'h0,        1'b0, 1, 8'h00, 0});
        tbl.push_back('{1'b0, 12'h104, 32'h0,        32'h0000CAFE, 1'b0, 2, 8'h01, 1});
        tbl.push_back('{1'b1, 12'h4A0, 32'hA5,       32'h0,        1'b0, 7, 8'h08, 6});
        tbl.push_back('{1'b0, 12'h210, 32'h0,        32'h0100CAFE, 1'b0, 3, 8'h02, 2});
        tbl.push_back('{1'b0, 12'h310, 32'h0,        32'h0200CAFE, 1'b0, 2, 8'h04, 1});
        tbl.push_back('{1'b0, 12'h000, 32'h0,        32'h0,        1'b1, 1, 8'h00, 0});
        tbl.push_back('{1'b0, 12'hFFE, 32'h0,        32'h101,      1'b0, 1, 8'h00, 0});
        tbl.push_back('{1'b1, 12'hFFE, 32'h0,        32'h0,        1'b0, 1, 8'h00, 0});
        tbl.push_back('{1'b0, 12'hFFE, 32'h0,        32'h0,        1'b0, 1, 8'h00, 0});
        tbl.push_back('{1'b0, 12'h600, 32'h0,        32'h0,        1'b1, -1, 8'h20, -1});
        tbl.push_back('{1'b0, 12'hFFE, 32'h0,        32'h101,      1'b0, 1, 8'h00, 0});
        tbl.push_back('{1'b0, 12'hFFF, 32'h0,        32'h0,        1'b0, 1, 8'h00, 0});
        tbl.push_back('{1'b1, 12'h508, 32'h1234,     32'h0,        1'b0, 4, 8'h10, 3});
        tbl.push_back('{1'b0, 12'h840, 32'h0,        32'h0700CAFE, 1'b0, 5, 8'h80, 4});
        tbl.push_back('{1'b0, 12'h8F0, 32'h0,        32'h0,        1'b1, 1, 8'h00, 0});
        tbl.push_back('{1'b0, 12'hFFE, 32'h0,        32'h102,      1'b0, 1, 8'h00, 0});
        tbl.push_back('{1'b0, 12'h7FF, 32'h0,        32'h0600CAFE, 1'b0, 2, 8'h40, 1});
        tbl.push_back('{1'b1, 12'h104, 32'h5555,     32'h0,        1'b0, 2, 8'h01, 1});

        foreach (tbl[k]) begin
            tag = $sformatf("v%0d", k);
            xfer(tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].rdata, tbl[k].err, tag);
            if (tbl[k].lat >= 0) check({tag, ".lat"}, 32'(r_lat), 32'(tbl[k].lat));
            check({tag, ".sel"}, 32'(r_selacc), 32'(tbl[k].sel));
            if (tbl[k].selcyc >= 0) check({tag, ".selcyc"}, 32'(r_selcyc), 32'(tbl[k].selcyc));
            if (tbl[k].we && tbl[k].sel != '0) begin
                check({tag, ".s_wdata"}, r_swd, tbl[k].wdata);
                check({tag, ".s_we"}, 32'(r_swe), 32'h1);
            end
        end

        // Soft reset pulse: one RESP cycle carrying the written bit pattern.
        xfer(1'b1, 12'hFFF, 32'h0000_0005, 32'h0, 1'b0, "srst");
        check("srst.pattern", 32'(r_rstacc), 32'h05);
        check("srst.cycles", 32'(r_rstcyc), 32'h1);
        check("srst.lat", 32'(r_lat), 32'h1);

        // Error counter saturation, then clear by STAT write.
        xfer(1'b1, 12'hFFE, 32'h0, 32'h0, 1'b0, "clr0");
        for (int i = 0; i < 256; i++)
            xfer(1'b0, 12'h900 | 12'(i), 32'h0, 32'h0, 1'b1, $sformatf("unm%0d", i));
        xfer(1'b0, 12'hFFE, 32'h0, 32'h1FF, 1'b0, "stat_sat");
        xfer(1'b1, 12'hFFE, 32'h0, 32'h0, 1'b0, "clr1");
        xfer(1'b0, 12'hFFE, 32'h0, 32'h0, 1'b0, "stat_clr");

        // Reset mid-ACCESS: leave an error recorded first so the reset clear is visible.
        xfer(1'b0, 12'h000, 32'h0, 32'h0, 1'b1, "pre_rst");
        @(posedge clk); #1;
        m_sel = 1'b1; m_we = 1'b0; m_addr = 12'h600; m_wdata = 32'h5A5A;
        repeat (4) @(negedge clk);
        check("mid.sel", 32'(s_sel), 32'h20);
        @(posedge clk); #1;
        rst = 1'b0; m_sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid");
        nrdy = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_ready) nrdy++;
        end
        check("mid.no_ready", 32'(nrdy), 32'h0);
        xfer(1'b0, 12'hFFE, 32'h0, 32'h0, 1'b0, "post_stat");
        xfer(1'b0, 12'h104, 32'h0, 32'h0000CAFE, 1'b0, "post_rd");
        check("post_rd.lat", 32'(r_lat), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
